// File: rtl/register_dump_unit.sv
// Streams N_REGISTER bank words out as little-endian bytes over a valid/ready link.
// Define DUMP_HEADER_EN to prefix each dump with an 8'hA5 marker byte.
module register_dump_unit #(
    parameter int NB_REG     = 5,
    parameter int NB_DATA    = 32,
    parameter int N_REGISTER = 32
) (
    input  logic               clock_i,
    input  logic               reset_i,
    input  logic               start_i,
    output logic [NB_REG-1:0]  addr_o,
    input  logic [NB_DATA-1:0] data_i,
    output logic [7:0]         tx_data_o,
    output logic               tx_valid_o,
    input  logic               tx_ready_i,
    output logic               busy_o,
    output logic               done_o
);

    localparam int NBYTES  = NB_DATA / 8;
    localparam int NB_BCNT = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    localparam logic [NB_BCNT-1:0] LAST_BYTE = NB_BCNT'(NBYTES - 1);
    localparam logic [NB_REG-1:0]  LAST_IDX  = NB_REG'(N_REGISTER - 1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_WAIT   = 3'd2;
    localparam logic [2:0] ST_LATCH  = 3'd3;
    localparam logic [2:0] ST_SEND   = 3'd4;
    localparam logic [2:0] ST_DONE   = 3'd5;
`ifdef DUMP_HEADER_EN
    localparam logic [2:0] ST_HEADER = 3'd6;
`endif

    logic [2:0]         state_q;
    logic [NB_REG-1:0]  index_q;
    logic [NB_BCNT-1:0] bcnt_q;
    logic [NB_BCNT-1:0] bcnt_nxt;
    logic [NB_DATA-1:0] word_q;
    logic               xfer;

    assign xfer     = tx_valid_o & tx_ready_i;
    assign bcnt_nxt = bcnt_q + 1'b1;

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= ST_IDLE;
            index_q    <= '0;
            bcnt_q     <= '0;
            word_q     <= '0;
            addr_o     <= '0;
            tx_data_o  <= '0;
            tx_valid_o <= 1'b0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_o <= 1'b0;
                    if (start_i) begin
                        index_q <= '0;
                        addr_o  <= '0;
                        busy_o  <= 1'b1;
`ifdef DUMP_HEADER_EN
                        tx_data_o  <= 8'hA5;
                        tx_valid_o <= 1'b1;
                        state_q    <= ST_HEADER;
`else
                        state_q <= ST_FETCH;
`endif
                    end
                end
`ifdef DUMP_HEADER_EN
                ST_HEADER: begin
                    if (xfer) begin
                        tx_valid_o <= 1'b0;
                        state_q    <= ST_FETCH;
                    end
                end
`endif
                // bank read is registered: data_i is valid by LATCH
                ST_FETCH: state_q <= ST_WAIT;
                ST_WAIT:  state_q <= ST_LATCH;
                ST_LATCH: begin
                    word_q     <= data_i;
                    bcnt_q     <= '0;
                    tx_data_o  <= data_i[7:0];
                    tx_valid_o <= 1'b1;
                    state_q    <= ST_SEND;
                end
                ST_SEND: begin
                    if (xfer) begin
                        if (bcnt_q != LAST_BYTE) begin
                            bcnt_q    <= bcnt_nxt;
                            tx_data_o <= word_q[8*int'(bcnt_nxt) +: 8];
                        end else begin
                            tx_valid_o <= 1'b0;
                            if (index_q < LAST_IDX) begin
                                index_q <= index_q + 1'b1;
                                addr_o  <= index_q + 1'b1;
                                state_q <= ST_FETCH;
                            end else begin
                                done_o  <= 1'b1;
                                state_q <= ST_DONE;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    done_o  <= 1'b0;
                    busy_o  <= 1'b0;
                    addr_o  <= '0;
                    index_q <= '0;
                    bcnt_q  <= '0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_register_dump_unit.sv
// Randomised bench for register_dump_unit with a queue-based byte stream model.
// Honours DUMP_HEADER_EN the same way as the design.
module tb_register_dump_unit;

    localparam int NB_REG  = 5;
    localparam int NB_DATA = 32;
    localparam int N_REG   = 32;
    localparam int NBYTES  = NB_DATA / 8;
`ifdef DUMP_HEADER_EN
    localparam int HDR = 1;
`else
    localparam int HDR = 0;
`endif
    localparam int TOTAL = HDR + N_REG * NBYTES;

    logic               clock_i = 1'b0;
    logic               reset_i;
    logic               start_i;
    logic [NB_REG-1:0]  addr_o;
    logic [NB_DATA-1:0] data_i = '0;
    logic [7:0]         tx_data_o;
    logic               tx_valid_o;
    logic               tx_ready_i;
    logic               busy_o;
    logic               done_o;

    register_dump_unit #(
        .NB_REG(NB_REG), .NB_DATA(NB_DATA), .N_REGISTER(N_REG)
    ) dut (
        .clock_i(clock_i), .reset_i(reset_i), .start_i(start_i),
        .addr_o(addr_o), .data_i(data_i), .tx_data_o(tx_data_o),
        .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
        .busy_o(busy_o), .done_o(done_o)
    );

    always #5 clock_i = ~clock_i;

    logic [NB_DATA-1:0] mem [N_REG];
    always @(posedge clock_i) data_i <= mem[addr_o];

    int checks = 0;
    int failures = 0;
    logic [7:0] expq[$];
    logic [7:0] rx[$];
    logic [7:0] ref_stream[$];
    int  done_cnt = 0;
    bit  active = 0;
    bit  rnd_ready = 0;
    bit  prev_stall = 0;
    bit  exp_done = 0;
    logic [7:0] prev_data = '0;

    task automatic check(input bit ok, input string name, input int act, input int req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: got %0h, want %0h at %0t", name, act, req, $time);
        end
    endtask

    always @(posedge clock_i) begin
        #1;
        tx_ready_i = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // one byte leaves on the next rising edge whenever valid and ready are seen here
    always @(negedge clock_i) begin
        if (reset_i) begin
            check(!tx_valid_o && !busy_o && !done_o && addr_o == 0 && tx_data_o == 0,
                  "reset_outputs", {tx_valid_o, busy_o, done_o, addr_o, tx_data_o}, 0);
            prev_stall = 0;
            exp_done = 0;
        end else begin
            check(done_o == exp_done, "done_timing", done_o, exp_done);
            check(busy_o == active, "busy", busy_o, active);
            check(!tx_valid_o || active, "valid_while_idle", tx_valid_o, 0);
            if (prev_stall)
                check(tx_valid_o && tx_data_o == prev_data, "stall_stable",
                      {tx_valid_o, tx_data_o}, {1'b1, prev_data});
            if (done_o) begin
                done_cnt++;
                active = 0;
            end
            exp_done = 0;
            if (tx_valid_o && tx_ready_i) begin
                check(expq.size() > 0, "extra_byte", tx_data_o, 0);
                if (expq.size() > 0) begin
                    logic [7:0] e;
                    e = expq.pop_front();
                    check(tx_data_o == e, "byte", tx_data_o, e);
                    rx.push_back(tx_data_o);
                    if (expq.size() == 0) exp_done = 1;
                end
            end
            prev_stall = tx_valid_o && !tx_ready_i;
            prev_data  = tx_data_o;
        end
    end

    task automatic start_dump();
        expq.delete();
        rx.delete();
        if (HDR == 1) expq.push_back(8'hA5);
        for (int k = 0; k < N_REG; k++)
            for (int b = 0; b < NBYTES; b++)
                expq.push_back(8'((mem[k] >> (8 * b)) & 32'hFF));
        @(posedge clock_i); #1;
        start_i = 1'b1;
        @(posedge clock_i); #1;
        start_i = 1'b0;
        active = 1;
    endtask

    task automatic wait_done(input bit poke_start);
        bit seen;
        seen = 0;
        for (int i = 0; i < 4000 && !seen; i++) begin
            @(negedge clock_i);
            if (done_o) seen = 1;
        end
        check(seen, "done_timeout", seen, 1);
        if (seen && poke_start) begin
            start_i = 1'b1;
            @(posedge clock_i); #1;
            start_i = 1'b0;
        end
        repeat (6) @(posedge clock_i);
        #1;
    endtask

    initial begin
        int d0;
        int mism;
        reset_i = 1'b1;
        start_i = 1'b0;
        tx_ready_i = 1'b1;
        for (int k = 0; k < N_REG; k++) mem[k] = 32'h0000_0101 * k;
        repeat (3) @(posedge clock_i);
        #1;
        check(tx_valid_o == 0, "rst_valid", tx_valid_o, 0);
        check(busy_o == 0, "rst_busy", busy_o, 0);
        check(done_o == 0, "rst_done", done_o, 0);
        check(addr_o == 0, "rst_addr", addr_o, 0);
        check(tx_data_o == 0, "rst_data", tx_data_o, 0);
        reset_i = 1'b0;
        repeat (3) @(posedge clock_i);

        // fixed pattern, ready held high, start poked during DONE
        start_dump();
`ifdef DUMP_HEADER_EN
        check(tx_valid_o == 1 && tx_data_o == 8'hA5, "hdr_first", tx_data_o, 8'hA5);
`else
        check(busy_o == 1 && tx_valid_o == 0, "lat_e0", {busy_o, tx_valid_o}, 2);
        for (int i = 1; i <= 2; i++) begin
            @(posedge clock_i); #1;
            check(tx_valid_o == 0, "lat_early", tx_valid_o, 0);
        end
        @(posedge clock_i); #1;
        check(tx_valid_o == 1 && tx_data_o == 8'h00, "lat_e3", {tx_valid_o, tx_data_o}, 9'h100);
`endif
        d0 = done_cnt;
        wait_done(1'b1);
        check(rx.size() == TOTAL, "count_a", rx.size(), TOTAL);
        check(done_cnt == d0 + 1, "done_once_a", done_cnt - d0, 1);
        if (rx.size() == TOTAL) begin
            check(rx[HDR+0] == 8'h00 && rx[HDR+1] == 8'h00 && rx[HDR+2] == 8'h00
                  && rx[HDR+3] == 8'h00, "lit_reg0", {rx[HDR+0], rx[HDR+1]}, 0);
            check(rx[HDR+4] == 8'h01 && rx[HDR+5] == 8'h01 && rx[HDR+6] == 8'h00
                  && rx[HDR+7] == 8'h00, "lit_reg1",
                  {rx[HDR+4], rx[HDR+5], rx[HDR+6], rx[HDR+7]}, 32'h0101_0000);
            check(rx[TOTAL-4] == 8'h1F && rx[TOTAL-3] == 8'h1F && rx[TOTAL-1] == 8'h00,
                  "lit_reg31", {rx[TOTAL-4], rx[TOTAL-3]}, 16'h1F1F);
`ifdef DUMP_HEADER_EN
            check(rx[0] == 8'hA5, "lit_hdr", rx[0], 8'hA5);
`endif
        end
        ref_stream = rx;

        // same pattern under random back-pressure
        rnd_ready = 1;
        start_dump();
        wait_done(1'b0);
        check(rx.size() == TOTAL, "count_b", rx.size(), TOTAL);
        mism = 0;
        for (int i = 0; i < TOTAL && i < rx.size(); i++)
            if (rx[i] != ref_stream[i]) mism++;
        check(mism == 0, "stream_b", mism, 0);

        // random contents, second start mid-dump
        for (int k = 0; k < N_REG; k++) mem[k] = $urandom;
        d0 = done_cnt;
        start_dump();
        for (int i = 0; i < 2000 && rx.size() < 20; i++) @(posedge clock_i);
        @(posedge clock_i); #1;
        start_i = 1'b1;
        @(posedge clock_i); #1;
        start_i = 1'b0;
        wait_done(1'b0);
        repeat (20) @(posedge clock_i);
        #1;
        check(rx.size() == TOTAL, "count_c", rx.size(), TOTAL);
        check(done_cnt == d0 + 1, "done_once_c", done_cnt - d0, 1);

        // reset after 50 bytes, then a clean dump
        rnd_ready = 0;
        start_dump();
        for (int i = 0; i < 2000 && rx.size() < 50; i++) begin
            @(posedge clock_i); #1;
        end
        check(rx.size() == 50, "reach_50", rx.size(), 50);
        reset_i = 1'b1;
        active = 0;
        #1;
        check(tx_valid_o == 0 && busy_o == 0, "reset_mid", {tx_valid_o, busy_o}, 0);
        expq.delete();
        repeat (2) @(posedge clock_i);
        #1;
        reset_i = 1'b0;
        repeat (10) @(posedge clock_i);
        #1;
        check(tx_valid_o == 0 && busy_o == 0, "quiet_after_rst", {tx_valid_o, busy_o}, 0);
        d0 = done_cnt;
        start_dump();
        wait_done(1'b0);
        check(rx.size() == TOTAL, "count_d", rx.size(), TOTAL);
        check(done_cnt == d0 + 1, "done_once_d", done_cnt - d0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
